// File: rtl/jk_chk_pkg.sv
// Shared types for the JK flip-flop response checker: FSM state encoding and
// JK operation codes as {j,k}.
package jk_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    FAIL   = 2'd3
  } state_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_ref_model.sv
// Golden 1-bit JK flop; runs on every edge out of reset, independent of the
// checker FSM, so it keeps tracking the DUT while checking is paused.
module jk_ref_model
  import jk_chk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      JK_HOLD: q_d = q_q;
      JK_RST:  q_d = 1'b0;
      JK_SET:  q_d = 1'b1;
      JK_TGL:  q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= 1'b0;
    else      q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/jk_ff_checker.sv
// Observe-side checker: compares N_OUT JK DUT outputs against a golden model and
// keeps saturating cycle/error counts plus a capture of the first failure.
//
// state  | meaning
// IDLE   | checking disabled, waiting for en
// SETTLE | en seen, waiting SETTLE_CYC cycles before comparing
// CHECK  | comparing q_obs against q_ref every enabled cycle
// FAIL   | stopped on first mismatch (STOP_ON_ERR), counters frozen until clr
module jk_ff_checker
  import jk_chk_pkg::*;
#(
  parameter int N_OUT       = 3,
  parameter int CNT_W       = 16,
  parameter int SETTLE_CYC  = 1,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             j,
  input  logic             k,
  input  logic [N_OUT-1:0] q_obs,
  output logic [CNT_W-1:0] checked_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag,
  output logic [N_OUT-1:0] first_err_mask,
  output logic [CNT_W-1:0] first_err_cycle,
  output logic             q_ref,
  output logic [1:0]       state_o
);

  localparam int               SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CNT_W-1:0]   chk_q, chk_d, err_q, err_d, fcyc_q, fcyc_d;
  logic               flag_q, flag_d;
  logic [N_OUT-1:0]   mask_q, mask_d;
  logic [N_OUT-1:0]   mism;
  logic               any_mism, do_check, q_ref_w;

  jk_ref_model u_ref (
    .clk (clk),
    .rst (rst),
    .j   (j),
    .k   (k),
    .q   (q_ref_w)
  );

  // q_ref_w is still the pre-edge model state here, matching the DUT's q_obs.
  assign mism     = q_obs ^ {N_OUT{q_ref_w}};
  assign any_mism = |mism;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (en) state_d = SETTLE;
        SETTLE:  if (!en) state_d = IDLE;
                 else if (settle_q == '0) state_d = CHECK;
        CHECK:   if (!en) state_d = IDLE;
                 else if ((STOP_ON_ERR != 0) && any_mism) state_d = FAIL;
        FAIL:    state_d = FAIL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    do_check = (state_q == CHECK) && en && !clr;
    settle_d = settle_q;
    if (state_q == IDLE && en)
      settle_d = SET_LOAD;
    else if (state_q == SETTLE && settle_q != '0)
      settle_d = settle_q - SET_W'(1);
  end

  always_comb begin
    chk_d  = chk_q;
    err_d  = err_q;
    flag_d = flag_q;
    mask_d = mask_q;
    fcyc_d = fcyc_q;
    if (clr) begin
      chk_d  = '0;
      err_d  = '0;
      flag_d = 1'b0;
      mask_d = '0;
      fcyc_d = '0;
    end else if (do_check) begin
      chk_d = (chk_q == CNT_MAX) ? chk_q : chk_q + CNT_W'(1);
      if (any_mism) begin
        err_d  = (err_q == CNT_MAX) ? err_q : err_q + CNT_W'(1);
        flag_d = 1'b1;
        if (!flag_q) begin
          mask_d = mism;
          fcyc_d = chk_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      settle_q <= '0;
      chk_q    <= '0;
      err_q    <= '0;
      flag_q   <= 1'b0;
      mask_q   <= '0;
      fcyc_q   <= '0;
    end else begin
      settle_q <= settle_d;
      chk_q    <= chk_d;
      err_q    <= err_d;
      flag_q   <= flag_d;
      mask_q   <= mask_d;
      fcyc_q   <= fcyc_d;
    end
  end

  assign checked_cnt     = chk_q;
  assign err_cnt         = err_q;
  assign err_flag        = flag_q;
  assign first_err_mask  = mask_q;
  assign first_err_cycle = fcyc_q;
  assign q_ref           = q_ref_w;
  assign state_o         = state_q;

endmodule

// File: tb/tb_jk_ff_checker.sv
// Bench for jk_ff_checker: three configurations share one stimulus stream and are
// compared each cycle against a run-length based behavioural model.
module tb_jk_ff_checker;

  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, clr = 1'b0, j = 1'b0, k = 1'b0;
  logic q_true = 1'b0;
  logic [2:0] flt [3];

  logic [2:0]  q_obs0, q_obs1, q_obs2;
  logic [15:0] chk0, err0, fcyc0, chk1, err1, fcyc1;
  logic [3:0]  chk2, err2, fcyc2;
  logic        flag0, flag1, flag2, qref0, qref1, qref2;
  logic [2:0]  mask0, mask1, mask2;
  logic [1:0]  st0, st1, st2;

  assign q_obs0 = {3{q_true}} ^ flt[0];
  assign q_obs1 = {3{q_true}} ^ flt[1];
  assign q_obs2 = {3{q_true}} ^ flt[2];

  always #5 clk = ~clk;

  jk_ff_checker #(.N_OUT(3), .CNT_W(16), .SETTLE_CYC(1), .STOP_ON_ERR(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .j(j), .k(k), .q_obs(q_obs0),
    .checked_cnt(chk0), .err_cnt(err0), .err_flag(flag0), .first_err_mask(mask0),
    .first_err_cycle(fcyc0), .q_ref(qref0), .state_o(st0));
  jk_ff_checker #(.N_OUT(3), .CNT_W(16), .SETTLE_CYC(1), .STOP_ON_ERR(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .j(j), .k(k), .q_obs(q_obs1),
    .checked_cnt(chk1), .err_cnt(err1), .err_flag(flag1), .first_err_mask(mask1),
    .first_err_cycle(fcyc1), .q_ref(qref1), .state_o(st1));
  jk_ff_checker #(.N_OUT(3), .CNT_W(4), .SETTLE_CYC(2), .STOP_ON_ERR(0)) u2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .j(j), .k(k), .q_obs(q_obs2),
    .checked_cnt(chk2), .err_cnt(err2), .err_flag(flag2), .first_err_mask(mask2),
    .first_err_cycle(fcyc2), .q_ref(qref2), .state_o(st2));

  localparam int P_MAX  [3] = '{65535, 65535, 15};
  localparam int P_SET  [3] = '{1, 1, 2};
  localparam int P_STOP [3] = '{0, 1, 0};

  // Model: "run" = consecutive enabled edges since the checker last went idle.
  int m_run [3], m_chk [3], m_err [3], m_mask [3], m_fcyc [3];
  bit m_flag [3], m_halt [3];
  bit m_q;
  int n_checks = 0, n_errors = 0;
  int saved;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit will_check(input int i);
    return en && !clr && !m_halt[i] && (m_run[i] >= P_SET[i] + 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_run[i] = 0; m_chk[i] = 0; m_err[i] = 0; m_mask[i] = 0; m_fcyc[i] = 0;
      m_flag[i] = 0; m_halt[i] = 0;
    end
    m_q = 0;
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      int mism;
      mism = int'(flt[i]);
      if (clr) begin
        m_run[i] = 0; m_chk[i] = 0; m_err[i] = 0; m_mask[i] = 0; m_fcyc[i] = 0;
        m_flag[i] = 0; m_halt[i] = 0;
      end else if (m_halt[i]) begin
        m_run[i] = m_run[i];
      end else if (!en) begin
        m_run[i] = 0;
      end else begin
        if (m_run[i] >= P_SET[i] + 1) begin
          if (mism != 0) begin
            if (!m_flag[i]) begin m_mask[i] = mism; m_fcyc[i] = m_chk[i]; end
            m_err[i]  = (m_err[i] < P_MAX[i]) ? m_err[i] + 1 : P_MAX[i];
            m_flag[i] = 1;
            if (P_STOP[i] != 0) m_halt[i] = 1;
          end
          m_chk[i] = (m_chk[i] < P_MAX[i]) ? m_chk[i] + 1 : P_MAX[i];
        end
        if (m_run[i] < 1000) m_run[i]++;
      end
    end
    if (j && k) m_q = !m_q;
    else if (j) m_q = 1;
    else if (k) m_q = 0;
  endtask

  function automatic int exp_state(input int i);
    if (m_halt[i]) return 3;
    if (m_run[i] == 0) return 0;
    if (m_run[i] <= P_SET[i]) return 1;
    return 2;
  endfunction

  task automatic cmp_one(input int i, input logic [1:0] st, input logic [31:0] c,
                         input logic [31:0] e, input logic fl, input logic [2:0] mk,
                         input logic [31:0] fc, input logic qr);
    check($sformatf("u%0d.state", i), 32'(st), exp_state(i));
    check($sformatf("u%0d.checked_cnt", i), c, m_chk[i]);
    check($sformatf("u%0d.err_cnt", i), e, m_err[i]);
    check($sformatf("u%0d.err_flag", i), 32'(fl), 32'(m_flag[i]));
    check($sformatf("u%0d.first_err_mask", i), 32'(mk), m_mask[i]);
    check($sformatf("u%0d.first_err_cycle", i), fc, m_fcyc[i]);
    check($sformatf("u%0d.q_ref", i), 32'(qr), 32'(m_q));
  endtask

  task automatic compare_all();
    cmp_one(0, st0, 32'(chk0), 32'(err0), flag0, mask0, 32'(fcyc0), qref0);
    cmp_one(1, st1, 32'(chk1), 32'(err1), flag1, mask1, 32'(fcyc1), qref1);
    cmp_one(2, st2, 32'(chk2), 32'(err2), flag2, mask2, 32'(fcyc2), qref2);
  endtask

  // Inputs only change after this returns, so the model sees the edge-sampled values.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rst) model_step();
    q_true = m_q;
    compare_all();
  endtask

  task automatic rand_jk();
    j = 1'($urandom_range(0, 1));
    k = 1'($urandom_range(0, 1));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) flt[i] = 3'b000;
    model_reset();

    // 1: reset held with J/K moving
    for (int n = 0; n < 2; n++) begin
      j = ~j; k = (n == 0);
      cyc();
    end
    check("reset.state_u0", 32'(st0), 0);
    check("reset.q_ref_u0", 32'(qref0), 0);

    // 2: clean run, JK 00,01,10,11 repeated
    rst = 1'b1; en = 1'b1; j = 0; k = 0;
    cyc();
    check("clean.enter_settle", 32'(st0), 1);
    for (int n = 0; n < 8; n++) begin
      j = 1'(n >> 1); k = 1'(n);
      cyc();
      if (n == 0) check("clean.enter_check", 32'(st0), 2);
    end
    check("clean.checked_cnt", 32'(chk0), 7);
    check("clean.err_cnt", 32'(err0), 0);
    check("clean.err_flag", 32'(flag0), 0);

    // 3 + 4: single fault on u0 check 3 bit1, stop-on-error u1 on check 2 bit0
    clr = 1'b1; cyc(); clr = 1'b0;
    for (int n = 0; n < 10; n++) begin
      rand_jk();
      flt[0] = (will_check(0) && m_chk[0] == 3) ? 3'b010 : 3'b000;
      flt[1] = (will_check(1) && m_chk[1] == 2) ? 3'b001 : 3'b000;
      cyc();
    end
    flt[0] = 3'b000; flt[1] = 3'b000;
    check("fault.err_cnt", 32'(err0), 1);
    check("fault.err_flag", 32'(flag0), 1);
    check("fault.first_mask", 32'(mask0), 32'h2);
    check("fault.first_cycle", 32'(fcyc0), 3);
    check("stop.state", 32'(st1), 3);
    check("stop.checked_frozen", 32'(chk1), 3);
    saved = int'(m_q);
    j = 0; k = 0; clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("stop.clr_checked", 32'(chk1), 0);
    check("stop.clr_err", 32'(err1), 0);
    check("stop.clr_state", 32'(st1), 0);
    check("stop.q_ref_kept", 32'(qref1), saved);

    // 5: saturation on the 4-bit instance
    for (int n = 0; n < 25; n++) begin
      rand_jk();
      flt[2] = 3'($urandom_range(1, 7));
      cyc();
    end
    flt[2] = 3'b000;
    check("sat.checked_cnt", 32'(chk2), 15);
    check("sat.err_cnt", 32'(err2), 15);
    check("sat.err_flag", 32'(flag2), 1);

    // 6: en dropped mid-CHECK while toggling
    clr = 1'b1; cyc(); clr = 1'b0;
    for (int n = 0; n < 6; n++) begin rand_jk(); cyc(); end
    saved = m_chk[0];
    en = 1'b0; j = 1; k = 1;
    for (int n = 0; n < 3; n++) cyc();
    check("pause.checked_held", 32'(chk0), saved);
    check("pause.state_idle", 32'(st0), 0);
    en = 1'b1;
    for (int n = 0; n < 8; n++) begin rand_jk(); cyc(); end
    check("resume.err_cnt", 32'(err0), 0);
    check("resume.checked_cnt", 32'(chk0), saved + 6);

    // random mix, with one asynchronous reset mid-run
    for (int n = 0; n < 400; n++) begin
      rand_jk();
      en  = ($urandom_range(0, 15) != 0);
      clr = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < 3; i++)
        flt[i] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      if (n == 200) begin
        #2 rst = 1'b0;
        model_reset();
        q_true = 1'b0;
        #1 compare_all();
        rst = 1'b1;
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
